key_press_conditioner: RTL and testbench
========================================

Name: key_press_conditioner

Overview:
- Front end for the digital lock FSM on the DE1-SoC.
- Takes the four raw push-button inputs and synchronises and debounces them.
- Emits one clean, single-cycle key event per physical press, as a one-hot code plus a valid strobe.
- Rejects chords (several keys pressed together) and enforces release-before-next-press, so the downstream lock sees each digit exactly once.

Parameters:
- DEBOUNCE_CYCLES, 500000 — cycles an input pattern must be stable to be accepted (10 ms at 50 MHz); minimum 2.
- TIMEOUT_CYCLES, 250000000 — inactivity window for the optional entry timeout (5 s at 50 MHz); minimum 2.
- KEY_ACTIVE_LOW, 1 — 1: key_raw bit = 0 means pressed (DE1-SoC KEY[3:0]); 0: active-high.

Ports:
- clock, input, 1 — system clock; all logic on rising edge.
- reset, input, 1 — asynchronous, active-high reset.
- key_raw, input, 4 — raw, asynchronous push-button levels.
- key_code, output, 4 — one-hot code of the last accepted key; held until the next accepted key.
- key_valid, output, 1 — one-cycle pulse when a new key_code is accepted.
- chord_error, output, 1 — one-cycle pulse when a debounced pattern has more than one bit set.
- key_busy, output, 1 — high whenever the FSM is not in IDLE.
- entry_timeout, output, 1 — present only with KEY_ENTRY_TIMEOUT_EN; one-cycle pulse.

Behaviour:
- Reset values (async, active-high): key_code=4'b0000, key_valid=0, chord_error=0, key_busy=0, entry_timeout=0, both sync flops = "not pressed", FSM=IDLE, counters=0.
- Reset asserted mid-press: everything returns to reset values immediately. After release of reset, a key still held is treated as a new press and goes through the full debounce.
- Input path:
  - Two-flop synchroniser on all 4 bits.
  - Synchroniser output is normalised to active-high "pressed" (inverted when KEY_ACTIVE_LOW=1); call this p[3:0].
  - p is first visible to the FSM after the 2nd rising edge following a raw change.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE. Counter cnt is wide enough for DEBOUNCE_CYCLES-1.
- IDLE:
  - p==0: stay.
  - p!=0: latch pat<=p, cnt<=0, go to DEBOUNCE.
- DEBOUNCE:
  - p==0: back to IDLE (bounce rejected); no output.
  - p!=pat but nonzero: pat<=p, cnt<=0, stay (restart).
  - p==pat and cnt<DEBOUNCE_CYCLES-1: cnt++.
  - p==pat and cnt==DEBOUNCE_CYCLES-1: go to HELD.
    - If pat is one-hot: key_code<=pat and key_valid=1 for that single cycle.
    - Otherwise: chord_error=1 for one cycle and key_code unchanged.
- HELD:
  - Wait for p==0, then cnt<=0 and go to RELEASE.
  - Adding or removing keys while held produces no event.
- RELEASE:
  - p!=0: back to HELD.
  - p==0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - Otherwise: cnt++.
- Latency: for a clean press first sampled at edge E1, key_valid is high for exactly the cycle following edge E(3+DEBOUNCE_CYCLES).
- Exactly one key_valid or chord_error per press-release cycle, never both. A new press is accepted only after DEBOUNCE_CYCLES of stable release.
- key_valid and chord_error are never asserted simultaneously and are never high for two consecutive cycles.

Optional Feature:
- Macro: KEY_ENTRY_TIMEOUT_EN.
- When defined:
  - entry_timeout port and a timeout counter are compiled in.
  - The counter is armed and cleared to 0 on every key_valid, and increments every cycle while armed.
  - On reaching TIMEOUT_CYCLES-1 it pulses entry_timeout for one cycle and disarms.
  - chord_error also clears and disarms it.
  - Reset disarms it.
  - The lock FSM uses entry_timeout to abandon a partially entered code.
- When not defined: no port, no counter. All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20, KEY_ACTIVE_LOW=1):
- Clean press: key_raw 4'hF -> 4'hE held 20 cycles, then released -> single key_valid pulse at edge E7 with key_code=4'b0001. No chord_error. key_busy falls 4 cycles after the release is synchronised.
- Bounce: key_raw toggles 4'hF/4'hB every 2 cycles for 12 cycles, then holds 4'hB -> no event during bouncing. Exactly one key_valid with key_code=4'b0100 after 4 stable cycles.
- Chord: key_raw=4'hC (KEY0+KEY1 pressed) held 10 cycles -> one chord_error pulse, key_valid stays 0, key_code retains its previous value.
- Release bounce: after an accepted press on KEY3, release with 2-cycle glitches back to pressed -> no second key_valid. The next key_valid occurs only after a fresh press following a 4-cycle stable release.
- Async reset mid-debounce: assert reset during DEBOUNCE with KEY2 held, deassert while still held -> all outputs 0 immediately. One key_valid with key_code=4'b0100 at 7 edges after reset release.
- With KEY_ENTRY_TIMEOUT_EN defined: accept KEY1, then idle -> entry_timeout pulses exactly once, 20 cycles after the key_valid, and not again. A second press before 20 cycles restarts the window.

Source files
------------

// File: rtl/key_press_conditioner.sv
// key_press_conditioner: synchronise, debounce and one-hot encode DE1-SoC push buttons (optional KEY_ENTRY_TIMEOUT_EN adds entry_timeout)
module key_press_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_raw,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       chord_error,
    output logic       key_busy
`ifdef KEY_ENTRY_TIMEOUT_EN
    ,
    output logic       entry_timeout
`endif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] RAW_IDLE = (KEY_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t state, state_nxt;
    logic [3:0] sync1, sync2, p, pat, pat_nxt, code_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic accept, valid_nxt, chord_nxt;

    assign p = (KEY_ACTIVE_LOW != 0) ? ~sync2 : sync2;
    assign key_busy = state != IDLE;

    // two-flop synchroniser, reset to the released level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // FSM state, pattern, counter and registered event outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pat         <= '0;
            cnt         <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            chord_error <= 1'b0;
        end else begin
            state       <= state_nxt;
            pat         <= pat_nxt;
            cnt         <= cnt_nxt;
            key_code    <= code_nxt;
            key_valid   <= valid_nxt;
            chord_error <= chord_nxt;
        end
    end

    // next state: debounce presses, then require a stable release before re-arming
    always_comb begin
        state_nxt = state;
        pat_nxt   = pat;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (p != 4'h0) begin
                pat_nxt   = p;
                cnt_nxt   = '0;
                state_nxt = DEBOUNCE;
            end
            DEBOUNCE: if (p == 4'h0) state_nxt = IDLE;
                else if (p != pat) begin
                    pat_nxt = p;
                    cnt_nxt = '0;
                end
                else if (cnt == CNT_MAX) state_nxt = HELD;
                else cnt_nxt = cnt + 1'b1;
            HELD: if (p == 4'h0) begin
                cnt_nxt   = '0;
                state_nxt = RELEASE;
            end
            RELEASE: if (p != 4'h0) state_nxt = HELD;
                else if (cnt == CNT_MAX) state_nxt = IDLE;
                else cnt_nxt = cnt + 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: a stable pattern yields a key event if one-hot, otherwise a chord error
    always_comb begin
        accept    = (state == DEBOUNCE) && (p == pat) && (cnt == CNT_MAX);
        valid_nxt = accept && $onehot(pat);
        chord_nxt = accept && !$onehot(pat);
        code_nxt  = valid_nxt ? pat : key_code;
    end

`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt;
    logic armed;

    // inactivity window restarted by every accepted key, cancelled by a chord
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt          <= '0;
            armed         <= 1'b0;
            entry_timeout <= 1'b0;
        end else begin
            entry_timeout <= 1'b0;
            if (valid_nxt || chord_nxt) begin
                tcnt  <= '0;
                armed <= valid_nxt;
            end else if (armed) begin
                if (tcnt == TMO_MAX) begin
                    entry_timeout <= 1'b1;
                    armed         <= 1'b0;
                end else tcnt <= tcnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_key_press_conditioner.sv
// tb_key_press_conditioner: directed self-checking bench for key_press_conditioner
module tb_key_press_conditioner;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] key_raw = 4'hF;
    logic [3:0] key_code;
    logic key_valid, chord_error, key_busy;
`ifdef KEY_ENTRY_TIMEOUT_EN
    logic entry_timeout;
    int nt, ft;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int base, nv, fv, nc, fc;

    key_press_conditioner #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20), .KEY_ACTIVE_LOW(1)) dut (
        .clock(clock),
        .reset(reset),
        .key_raw(key_raw),
        .key_code(key_code),
        .key_valid(key_valid),
        .chord_error(chord_error),
        .key_busy(key_busy)
`ifdef KEY_ENTRY_TIMEOUT_EN
        ,
        .entry_timeout(entry_timeout)
`endif
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
        cyc++;
        if (key_valid) begin
            if (nv == 0) fv = cyc;
            nv++;
        end
        if (chord_error) begin
            if (nc == 0) fc = cyc;
            nc++;
        end
`ifdef KEY_ENTRY_TIMEOUT_EN
        if (entry_timeout) begin
            if (nt == 0) ft = cyc;
            nt++;
        end
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_mon;
        base = cyc;
        nv = 0; fv = 0; nc = 0; fc = 0;
`ifdef KEY_ENTRY_TIMEOUT_EN
        nt = 0; ft = 0;
`endif
    endtask

    task automatic test_reset;
        clear_mon();
        steps(3);
        n_cmp += 4;
        if (key_code !== 4'h0) begin n_err++; $display("FAIL reset_code got %h want 0", key_code); end
        if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", key_valid); end
        if (chord_error !== 1'b0) begin n_err++; $display("FAIL reset_chord got %b want 0", chord_error); end
        if (key_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", key_busy); end
        #3 reset = 1'b0;
        steps(2);
    endtask

    task automatic test_clean_press;
        clear_mon();
        key_raw = 4'hE;
        steps(20);
        n_cmp += 5;
        if (nv !== 1) begin n_err++; $display("FAIL clean_count got %0d want 1", nv); end
        if (fv !== base + 7) begin n_err++; $display("FAIL clean_latency got %0d want %0d", fv - base, 7); end
        if (nc !== 0) begin n_err++; $display("FAIL clean_chord got %0d want 0", nc); end
        if (key_code !== 4'b0001) begin n_err++; $display("FAIL clean_code got %b want 0001", key_code); end
        if (key_busy !== 1'b1) begin n_err++; $display("FAIL clean_busy_held got %b want 1", key_busy); end
        clear_mon();
        key_raw = 4'hF;
        steps(6);
        n_cmp++;
        if (key_busy !== 1'b1) begin n_err++; $display("FAIL release_busy_early got %b want 1", key_busy); end
        step();
        n_cmp++;
        if (key_busy !== 1'b0) begin n_err++; $display("FAIL release_busy_fall got %b want 0", key_busy); end
        steps(5);
        n_cmp++;
        if (nv !== 0) begin n_err++; $display("FAIL release_valid got %0d want 0", nv); end
    endtask

    task automatic test_bounce;
        clear_mon();
        for (int k = 0; k < 6; k++) begin
            key_raw = (k % 2 == 0) ? 4'hB : 4'hF;
            steps(2);
        end
        n_cmp += 2;
        if (nv !== 0) begin n_err++; $display("FAIL bounce_spurious got %0d want 0", nv); end
        if (nc !== 0) begin n_err++; $display("FAIL bounce_chord got %0d want 0", nc); end
        clear_mon();
        key_raw = 4'hB;
        steps(15);
        n_cmp += 3;
        if (nv !== 1) begin n_err++; $display("FAIL bounce_count got %0d want 1", nv); end
        if (fv !== base + 7) begin n_err++; $display("FAIL bounce_latency got %0d want 7", fv - base); end
        if (key_code !== 4'b0100) begin n_err++; $display("FAIL bounce_code got %b want 0100", key_code); end
        key_raw = 4'hF;
        steps(10);
    endtask

    task automatic test_chord;
        clear_mon();
        key_raw = 4'hC;
        steps(10);
        n_cmp += 4;
        if (nc !== 1) begin n_err++; $display("FAIL chord_count got %0d want 1", nc); end
        if (fc !== base + 7) begin n_err++; $display("FAIL chord_latency got %0d want 7", fc - base); end
        if (nv !== 0) begin n_err++; $display("FAIL chord_valid got %0d want 0", nv); end
        if (key_code !== 4'b0100) begin n_err++; $display("FAIL chord_code got %b want 0100", key_code); end
        key_raw = 4'hF;
        steps(10);
    endtask

    task automatic test_release_bounce;
        clear_mon();
        key_raw = 4'h7;
        steps(10);
        n_cmp += 2;
        if (nv !== 1) begin n_err++; $display("FAIL k3_count got %0d want 1", nv); end
        if (key_code !== 4'b1000) begin n_err++; $display("FAIL k3_code got %b want 1000", key_code); end
        clear_mon();
        for (int k = 0; k < 4; k++) begin
            key_raw = (k % 2 == 0) ? 4'hF : 4'h7;
            steps(2);
        end
        key_raw = 4'hF;
        steps(12);
        n_cmp += 2;
        if (nv !== 0) begin n_err++; $display("FAIL relbounce_valid got %0d want 0", nv); end
        if (key_busy !== 1'b0) begin n_err++; $display("FAIL relbounce_idle got %b want 0", key_busy); end
        clear_mon();
        key_raw = 4'h7;
        steps(10);
        n_cmp += 2;
        if (nv !== 1) begin n_err++; $display("FAIL fresh_count got %0d want 1", nv); end
        if (fv !== base + 7) begin n_err++; $display("FAIL fresh_latency got %0d want 7", fv - base); end
        clear_mon();
        key_raw = 4'hF;
        steps(3);
        key_raw = 4'hE;
        steps(10);
        n_cmp += 2;
        if (nv !== 0) begin n_err++; $display("FAIL early_press_valid got %0d want 0", nv); end
        if (nc !== 0) begin n_err++; $display("FAIL early_press_chord got %0d want 0", nc); end
        key_raw = 4'hF;
        steps(10);
        n_cmp++;
        if (key_busy !== 1'b0) begin n_err++; $display("FAIL early_press_idle got %b want 0", key_busy); end
    endtask

    task automatic test_async_reset;
        key_raw = 4'hB;
        steps(4);
        n_cmp++;
        if (key_busy !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy got %b want 1", key_busy); end
        #2 reset = 1'b1;
        #1;
        n_cmp += 3;
        if (key_code !== 4'h0) begin n_err++; $display("FAIL arst_code got %b want 0000", key_code); end
        if (key_busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %b want 0", key_busy); end
        if (key_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", key_valid); end
        #2 reset = 1'b0;
        clear_mon();
        steps(12);
        n_cmp += 3;
        if (nv !== 1) begin n_err++; $display("FAIL arst_count got %0d want 1", nv); end
        if (fv !== base + 7) begin n_err++; $display("FAIL arst_latency got %0d want 7", fv - base); end
        if (key_code !== 4'b0100) begin n_err++; $display("FAIL arst_newcode got %b want 0100", key_code); end
        key_raw = 4'hF;
        steps(10);
    endtask

`ifdef KEY_ENTRY_TIMEOUT_EN
    task automatic test_timeout;
        clear_mon();
        key_raw = 4'hD;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 20) key_raw = 4'hF;
        end
        n_cmp += 3;
        if (nv !== 1) begin n_err++; $display("FAIL tmo_valid got %0d want 1", nv); end
        if (nt !== 1) begin n_err++; $display("FAIL tmo_count got %0d want 1", nt); end
        if (ft !== base + 27) begin n_err++; $display("FAIL tmo_latency got %0d want 27", ft - base); end
        clear_mon();
        key_raw = 4'hD;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (i == 8) key_raw = 4'hF;
            if (i == 15) key_raw = 4'hE;
            if (i == 30) key_raw = 4'hF;
        end
        n_cmp += 3;
        if (nv !== 2) begin n_err++; $display("FAIL tmo_restart_valid got %0d want 2", nv); end
        if (nt !== 1) begin n_err++; $display("FAIL tmo_restart_count got %0d want 1", nt); end
        if (ft !== base + 42) begin n_err++; $display("FAIL tmo_restart_latency got %0d want 42", ft - base); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_chord();
        test_release_bounce();
        test_async_reset();
`ifdef KEY_ENTRY_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
